// File: rtl/spi_flash_resp.sv
`default_nettype none
// ============================================================================
// spi_flash_resp : SPI-flash slave responder (READ, RDID, RDSR, WREN, WRDI)
// Revision       : 1.0
// ============================================================================
module spi_flash_resp #(
    parameter int          ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk_24m,
    input  logic              rst,
    input  logic              spi_clk_i,
    input  logic              spi_csn_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              wel
);

    localparam logic [7:0] c_cmd_read = 8'h03;
    localparam logic [7:0] c_cmd_rdid = 8'h9F;
    localparam logic [7:0] c_cmd_rdsr = 8'h05;
    localparam logic [7:0] c_cmd_wren = 8'h06;
    localparam logic [7:0] c_cmd_wrdi = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_RD     = 3'd3,
        S_ID     = 3'd4,
        S_SR     = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic              csn_meta_q, csn_meta_d, csn_sync_q, csn_sync_d, csn_prev_q, csn_prev_d;
    logic              mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
    logic [1:0]        warm_q, warm_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic              boundary_q, boundary_d;
    logic              fetch_q, fetch_d;
    logic [7:0]        prefetch_q, prefetch_d;
    logic              wel_q, wel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;

    logic              w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_resp;
    logic [7:0]        w_rx_byte, w_id_byte;

    // CS-fall detection waits until the whole sync pipeline holds real samples,
    // so a reset released mid-frame cannot fake a frame start.
    assign w_sck_rise = sck_sync_q & ~sck_prev_q;
    assign w_sck_fall = ~sck_sync_q & sck_prev_q;
    assign w_cs_fall  = (warm_q == 2'd3) & csn_prev_q & ~csn_sync_q;
    assign w_cs_rise  = csn_sync_q & ~csn_prev_q;
    assign w_rx_byte  = {rx_q[6:0], mosi_sync_q};

    always_comb begin
        case (byte_cnt_q)
            3'd1:    w_id_byte = JEDEC_ID[23:16];
            3'd2:    w_id_byte = JEDEC_ID[15:8];
            3'd3:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = 8'h00;
        endcase
    end

    always_comb begin
        sck_meta_d  = spi_clk_i;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        csn_meta_d  = spi_csn_i;
        csn_sync_d  = csn_meta_q;
        csn_prev_d  = csn_sync_q;
        mosi_meta_d = spi_mosi_i;
        mosi_sync_d = mosi_meta_q;
        warm_d      = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        boundary_d  = boundary_q;
        fetch_d     = mem_re_q;
        prefetch_d  = fetch_q ? mem_rdata : prefetch_q;
        wel_d       = wel_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        miso_d      = miso_q;

        if (w_cs_rise) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            boundary_d = 1'b0;
            tx_d       = 8'h00;
        end else if (w_cs_fall) begin
            state_d    = S_CMD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            boundary_d = 1'b0;
            rx_d       = 8'h00;
            tx_d       = 8'h00;
        end else if (state_q != S_IDLE) begin
            if (w_sck_rise) begin
                rx_d      = w_rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                // Only the low ADDR_W address bits survive the shift.
                if (state_q == S_ADDR)
                    mem_addr_d = {mem_addr_q[ADDR_W-2:0], mosi_sync_q};
                if (bit_cnt_q == 3'd7) begin
                    boundary_d = 1'b1;
                    if (byte_cnt_q != 3'd7)
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    case (state_q)
                        S_CMD: begin
                            case (w_rx_byte)
                                c_cmd_read: state_d = S_ADDR;
                                c_cmd_rdid: state_d = S_ID;
                                c_cmd_rdsr: state_d = S_SR;
                                c_cmd_wren: begin
                                    wel_d   = 1'b1;
                                    state_d = S_IGNORE;
                                end
                                c_cmd_wrdi: begin
                                    wel_d   = 1'b0;
                                    state_d = S_IGNORE;
                                end
                                default:    state_d = S_IGNORE;
                            endcase
                        end
                        S_ADDR: begin
                            if (byte_cnt_q == 3'd3) begin
                                mem_re_d = 1'b1;
                                state_d  = S_RD;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (w_sck_fall) begin
                if (boundary_q) begin
                    boundary_d = 1'b0;
                    case (state_q)
                        S_RD: begin
                            tx_d       = prefetch_q;
                            mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            mem_re_d   = 1'b1;
                        end
                        S_ID:    tx_d = w_id_byte;
                        S_SR:    tx_d = {6'b0, wel_q, 1'b0};
                        default: tx_d = 8'h00;
                    endcase
                    miso_d = tx_d[7];
                end else begin
                    tx_d   = {tx_q[6:0], 1'b0};
                    miso_d = tx_q[6];
                end
            end
        end

        w_resp    = (state_d == S_RD) || (state_d == S_ID) || (state_d == S_SR);
        miso_oe_d = w_resp;
        if (!w_resp)
            miso_d = 1'b0;
    end

    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            csn_meta_q  <= 1'b1;
            csn_sync_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            warm_q      <= 2'd0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            boundary_q  <= 1'b0;
            fetch_q     <= 1'b0;
            prefetch_q  <= 8'h00;
            wel_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            csn_meta_q  <= csn_meta_d;
            csn_sync_q  <= csn_sync_d;
            csn_prev_q  <= csn_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            warm_q      <= warm_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            boundary_q  <= boundary_d;
            fetch_q     <= fetch_d;
            prefetch_q  <= prefetch_d;
            wel_q       <= wel_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign wel         = wel_q;

endmodule
`default_nettype wire
